// File: rtl/mem_arbiter_2r.sv
// Round-robin arbiter for two requesters sharing one in-order memory channel; it steers responses back through an ordered owner tracker.
// Both the request and response paths are combinational. A stalled offer locks the grant until it is accepted. Issue stops while the tracker is full.
module mem_arbiter_2r #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int OT_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] r0_req_addr,
    input  logic          r0_req_wen,
    input  logic [DW-1:0] r0_req_wdata,
    input  logic          r0_req_valid,
    output logic          r0_req_ready,
    input  logic [AW-1:0] r1_req_addr,
    input  logic          r1_req_wen,
    input  logic [DW-1:0] r1_req_wdata,
    input  logic          r1_req_valid,
    output logic          r1_req_ready,
    output logic [DW-1:0] r0_resp_rdata,
    output logic          r0_resp_valid,
    output logic [DW-1:0] r1_resp_rdata,
    output logic          r1_resp_valid,
    output logic [AW-1:0] m_req_addr,
    output logic          m_req_wen,
    output logic [DW-1:0] m_req_wdata,
    output logic          m_req_valid,
    input  logic          m_req_ready,
    input  logic [DW-1:0] m_resp_rdata,
    input  logic          m_resp_valid,
    output logic [2:0]    ot_count,
    output logic          err_orphan_resp
);
    localparam int PW = (OT_DEPTH > 2) ? 2 : 1;
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]          r_state;
    logic                r_prio;
    logic                r_lock;
    logic [OT_DEPTH-1:0] r_owner;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [2:0]          r_ot_count;

    logic w_sel;
    logic w_sel_vld;
    logic w_full;
    logic w_empty;
    logic w_hs;
    logic w_pop;
    logic w_head_owner;

    // While HOLD, only the locked requester may drive the channel.
    always_comb begin
        w_sel = 1'b0;
        if (r_state == ST_HOLD)
            w_sel = r_lock;
        else if (r0_req_valid && r1_req_valid)
            w_sel = r_prio;
        else
            w_sel = r1_req_valid;
    end

    assign w_sel_vld    = w_sel ? r1_req_valid : r0_req_valid;
    assign w_full       = (r_ot_count == 3'(OT_DEPTH));
    assign w_empty      = (r_ot_count == 3'd0);
    assign m_req_valid  = rst_n && w_sel_vld && !w_full;
    assign w_hs         = m_req_valid && m_req_ready;
    assign m_req_addr   = w_sel ? r1_req_addr  : r0_req_addr;
    assign m_req_wen    = w_sel ? r1_req_wen   : r0_req_wen;
    assign m_req_wdata  = w_sel ? r1_req_wdata : r0_req_wdata;
    assign r0_req_ready = w_hs && !w_sel;
    assign r1_req_ready = w_hs && w_sel;

    assign w_pop           = rst_n && m_resp_valid && !w_empty;
    assign w_head_owner    = r_owner[r_head];
    assign r0_resp_valid   = w_pop && !w_head_owner;
    assign r1_resp_valid   = w_pop && w_head_owner;
    assign r0_resp_rdata   = m_resp_rdata;
    assign r1_resp_rdata   = m_resp_rdata;
    assign err_orphan_resp = rst_n && m_resp_valid && w_empty;
    assign ot_count        = r_ot_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_prio  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_hs) begin
                        r_prio <= !w_sel;
                    end else if (m_req_valid) begin
                        r_state <= ST_HOLD;
                        r_lock  <= w_sel;
                    end
                end
                ST_HOLD: begin
                    if (w_hs) begin
                        r_state <= ST_ARB;
                        r_prio  <= !r_lock;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_ot_count <= 3'd0;
        end else begin
            if (w_hs) begin
                r_owner[r_tail] <= w_sel;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            case ({w_hs, w_pop})
                2'b10:   r_ot_count <= r_ot_count + 3'd1;
                2'b01:   r_ot_count <= r_ot_count - 3'd1;
                default: r_ot_count <= r_ot_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_2r.sv
// Scoreboard bench for mem_arbiter_2r: a queue-based reference model predicts grants, counts and response routing.
module tb_mem_arbiter_2r;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 2;

    typedef struct { bit owner; logic [63:0] addr; bit wen; logic [63:0] wdata; } req_t;
    typedef struct { bit orphan; bit owner; logic [63:0] data; } resp_t;
    typedef struct { int cnt; bit mvld; } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] r0_req_addr, r1_req_addr, m_req_addr;
    logic [DW-1:0] r0_req_wdata, r1_req_wdata, m_req_wdata;
    logic          r0_req_wen, r1_req_wen, m_req_wen;
    logic          r0_req_valid, r1_req_valid, r0_req_ready, r1_req_ready;
    logic [DW-1:0] r0_resp_rdata, r1_resp_rdata, m_resp_rdata;
    logic          r0_resp_valid, r1_resp_valid;
    logic          m_req_valid, m_req_ready, m_resp_valid;
    logic [2:0]    ot_count;
    logic          err_orphan_resp;

    mem_arbiter_2r #(.AW(AW), .DW(DW), .OT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_addr(r0_req_addr), .r0_req_wen(r0_req_wen), .r0_req_wdata(r0_req_wdata),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r1_req_addr(r1_req_addr), .r1_req_wen(r1_req_wen), .r1_req_wdata(r1_req_wdata),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r0_resp_rdata(r0_resp_rdata), .r0_resp_valid(r0_resp_valid),
        .r1_resp_rdata(r1_resp_rdata), .r1_resp_valid(r1_resp_valid),
        .m_req_addr(m_req_addr), .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_resp_rdata(m_resp_rdata), .m_resp_valid(m_resp_valid),
        .ot_count(ot_count), .err_orphan_resp(err_orphan_resp)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    cyc_t  exp_cyc[$];

    // Reference model: outstanding owners in issue order, priority, and the requester whose offer is pending.
    bit          mdl_q[$];
    bit          mdl_prio = 1'b0;
    int          mdl_held = -1;
    logic [63:0] held_addr;

    bit          nx_v0, nx_v1, nx_rdy, nx_respv;
    logic [63:0] nx_rdata;
    logic [63:0] nx_a[2];
    logic [63:0] nx_d[2];
    bit          nx_w[2];
    bit          last_hs, last_sel;
    bit          pend[2];
    bit          gen_new;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic new_payload(input int n);
        nx_a[n] = rnd64();
        nx_d[n] = rnd64();
        nx_w[n] = 1'($urandom % 2);
    endtask

    // One clock cycle: apply stimulus after the edge, predict this cycle, then settle just past the falling edge.
    task automatic step();
        bit v[2];
        bit sel, selv, full, mvld, hs;
        @(posedge clk); #1;
        r0_req_valid = nx_v0; r0_req_addr = nx_a[0]; r0_req_wen = nx_w[0]; r0_req_wdata = nx_d[0];
        r1_req_valid = nx_v1; r1_req_addr = nx_a[1]; r1_req_wen = nx_w[1]; r1_req_wdata = nx_d[1];
        m_req_ready = nx_rdy; m_resp_valid = nx_respv; m_resp_rdata = nx_rdata;
        v[0] = nx_v0; v[1] = nx_v1;
        full = (mdl_q.size() >= DEPTH);
        if (mdl_held >= 0) begin
            sel  = (mdl_held == 1);
            selv = v[sel];
            chk("lock_stable", 64'(v[sel] && nx_a[sel] == held_addr), 64'd1);
        end else begin
            sel  = (v[0] && v[1]) ? mdl_prio : v[1];
            selv = v[0] || v[1];
        end
        mvld = selv && !full;
        hs   = mvld && nx_rdy;
        exp_cyc.push_back('{mdl_q.size(), mvld});
        if (nx_respv) begin
            if (mdl_q.size() == 0) exp_resp.push_back('{1'b1, 1'b0, nx_rdata});
            else                   exp_resp.push_back('{1'b0, mdl_q.pop_front(), nx_rdata});
        end
        if (hs) begin
            exp_req.push_back('{sel, nx_a[sel], nx_w[sel], nx_d[sel]});
            mdl_q.push_back(sel);
            mdl_prio = !sel;
            mdl_held = -1;
        end else if (mvld) begin
            mdl_held  = sel ? 1 : 0;
            held_addr = nx_a[sel];
        end
        last_hs = hs; last_sel = sel;
        if (hs) new_payload(sel ? 1 : 0);
        @(negedge clk); #1;
    endtask

    task automatic rand_step();
        for (int n = 0; n < 2; n++)
            if (!pend[n] && gen_new && ($urandom % 3 == 0)) pend[n] = 1'b1;
        nx_v0    = pend[0];
        nx_v1    = pend[1];
        nx_rdy   = ($urandom % 4 != 0);
        nx_respv = (mdl_q.size() > 0) ? 1'($urandom % 2) : ($urandom % 16 == 0);
        nx_rdata = rnd64();
        step();
        if (last_hs) pend[last_sel] = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        cyc_t  c;
        req_t  r;
        resp_t p;
        if (mon_en) begin
            if (exp_cyc.size() == 0) begin
                chk("cyc_underflow", 64'd1, 64'd0);
            end else begin
                c = exp_cyc.pop_front();
                chk("ot_count", 64'(ot_count), 64'(c.cnt));
                chk("m_req_valid", 64'(m_req_valid), 64'(c.mvld));
            end
            if (m_req_valid && m_req_ready) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 64'd1, 64'd0);
                end else begin
                    r = exp_req.pop_front();
                    chk("req_owner", 64'({r1_req_ready, r0_req_ready}), r.owner ? 64'd2 : 64'd1);
                    chk("req_addr", m_req_addr, r.addr);
                    chk("req_wen", 64'(m_req_wen), 64'(r.wen));
                    chk("req_wdata", m_req_wdata, r.wdata);
                end
            end
            if (r0_resp_valid || r1_resp_valid || err_orphan_resp) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    p = exp_resp.pop_front();
                    chk("resp_route", 64'({err_orphan_resp, r1_resp_valid, r0_resp_valid}),
                        p.orphan ? 64'd4 : (p.owner ? 64'd2 : 64'd1));
                    chk("r0_rdata", r0_resp_rdata, p.data);
                    chk("r1_rdata", r1_resp_rdata, p.data);
                end
            end
        end
    end

    initial begin
        r0_req_valid = 0; r1_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        r0_req_addr = '0; r1_req_addr = '0; r0_req_wen = 0; r1_req_wen = 0;
        r0_req_wdata = '0; r1_req_wdata = '0; m_resp_rdata = '0;
        nx_v0 = 0; nx_v1 = 0; nx_rdy = 0; nx_respv = 0; nx_rdata = '0;
        new_payload(0); new_payload(1);
        pend[0] = 0; pend[1] = 0; gen_new = 0;

        // Reset state, with live inputs that would otherwise raise outputs.
        #11;
        r0_req_valid = 1; m_req_ready = 1; m_resp_valid = 1;
        #1;
        chk("rst_ot_count", 64'(ot_count), 64'd0);
        chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst_r0_req_ready", 64'(r0_req_ready), 64'd0);
        chk("rst_resp_valid", 64'({r1_resp_valid, r0_resp_valid}), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan_resp), 64'd0);
        r0_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        @(negedge clk); rst_n = 1; #1; mon_en = 1;

        // Contention with ready high: r0, r1, r0, r1; responses A0..A3.
        nx_v0 = 1; nx_v1 = 1; nx_rdy = 1; nx_respv = 0;
        step();
        chk("cont_gnt0", 64'(r0_req_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            nx_respv = 1; nx_rdata = 64'hA0 + 64'(i - 1);
            step();
            chk("cont_gnt_r0", 64'(r0_req_ready), 64'(i % 2 == 0));
            chk("cont_resp_r0", 64'(r0_resp_valid), 64'(i % 2));
        end
        nx_v0 = 0; nx_v1 = 0; nx_rdata = 64'hA3;
        step();
        chk("cont_last_r1", 64'(r1_resp_valid), 64'd1);
        chk("cont_last_data", r1_resp_rdata, 64'hA3);
        nx_respv = 0;

        // Stall lock: r1 holds the grant through three unready cycles.
        nx_a[1] = 64'h1000; nx_v1 = 1; nx_rdy = 0;
        step();
        chk("stall_addr", m_req_addr, 64'h1000);
        chk("stall_r0_rdy", 64'(r0_req_ready), 64'd0);
        nx_v0 = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr", m_req_addr, 64'h1000);
            chk("stall_r0_rdy", 64'(r0_req_ready), 64'd0);
        end
        nx_rdy = 1;
        step();
        chk("stall_r1_acc", 64'({r1_req_ready, r0_req_ready}), 64'd2);
        nx_v1 = 0;
        step();
        chk("stall_r0_next", 64'(r0_req_ready), 64'd1);

        // Full: two outstanding blocks issue, even with a response that cycle.
        step();
        chk("full_cnt", 64'(ot_count), 64'd2);
        chk("full_blk", 64'(m_req_valid), 64'd0);
        nx_respv = 1; nx_rdata = 64'hB0;
        step();
        chk("full_resp_blk", 64'(m_req_valid), 64'd0);
        chk("full_resp_r1", 64'(r1_resp_valid), 64'd1);
        nx_respv = 0;
        step();
        chk("full_after_cnt", 64'(ot_count), 64'd1);
        chk("full_after_vld", 64'(m_req_valid), 64'd1);
        nx_v0 = 0; nx_respv = 1;
        step(); step();
        nx_respv = 0;

        // Simultaneous push and pop at one outstanding, across pointer wrap.
        nx_v0 = 1;
        step();
        nx_v1 = 1; nx_respv = 1;
        for (int i = 0; i < 8; i++) begin
            nx_rdata = rnd64();
            step();
            chk("pp_cnt", 64'(ot_count), 64'd1);
        end
        nx_v0 = 0; nx_v1 = 0; nx_rdata = rnd64();
        step();
        nx_respv = 0;

        // Orphan response.
        nx_respv = 1; nx_rdata = 64'hDEAD;
        step();
        chk("orphan_pulse", 64'(err_orphan_resp), 64'd1);
        chk("orphan_no_resp", 64'({r1_resp_valid, r0_resp_valid}), 64'd0);
        nx_respv = 0;
        step();
        chk("orphan_clear", 64'(err_orphan_resp), 64'd0);

        // Randomized traffic, then drain.
        gen_new = 1;
        repeat (400) rand_step();
        gen_new = 0;
        for (int i = 0; i < 60 && (pend[0] || pend[1] || mdl_q.size() > 0); i++) rand_step();
        chk("drain_done", 64'(pend[0] || pend[1] || mdl_q.size() > 0), 64'd0);
        nx_v0 = 0; nx_v1 = 0; nx_respv = 0; nx_rdy = 0;

        // Reset mid-flight with two outstanding.
        nx_v0 = 1; nx_rdy = 1;
        step(); step();
        nx_v0 = 0;
        step();
        chk("mid_cnt", 64'(ot_count), 64'd2);
        mon_en = 0;
        r0_req_valid = 1; m_req_ready = 1; m_resp_valid = 1;
        #1 rst_n = 0;
        #1;
        chk("mid_rst_cnt", 64'(ot_count), 64'd0);
        chk("mid_rst_mvld", 64'(m_req_valid), 64'd0);
        chk("mid_rst_rdy", 64'({r1_req_ready, r0_req_ready}), 64'd0);
        chk("mid_rst_resp", 64'({r1_resp_valid, r0_resp_valid}), 64'd0);
        chk("mid_rst_err", 64'(err_orphan_resp), 64'd0);
        @(posedge clk); #2;
        r0_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        rst_n = 1;
        mdl_q.delete(); mdl_prio = 0; mdl_held = -1;
        @(negedge clk); #1; mon_en = 1;
        step();
        chk("post_rst_cnt", 64'(ot_count), 64'd0);
        chk("post_rst_err", 64'(err_orphan_resp), 64'd0);
        nx_respv = 1;
        for (int i = 0; i < 2; i++) begin
            nx_rdata = rnd64();
            step();
            chk("late_orphan", 64'(err_orphan_resp), 64'd1);
            chk("late_no_resp", 64'({r1_resp_valid, r0_resp_valid}), 64'd0);
        end
        nx_respv = 0;
        step();

        chk("req_left", 64'(exp_req.size()), 64'd0);
        chk("resp_left", 64'(exp_resp.size()), 64'd0);
        chk("cyc_left", 64'(exp_cyc.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_2r.md
# mem_arbiter_2r

Two-requester memory arbiter. Instruction fetch (r0) and load/store (r1) share one in-order memory request channel. The block issues requests round-robin, keeps the grant locked while an offered request stalls, and records each issued request's owner in an ordered tracker. Each in-order response is steered back to the requester that issued it. It sits between the front-end/LSU request ports and the single L1/bus interface, upstream of the 2-deep fetch FIFO.

## Interface
- AW, 64, address width
- DW, 64, data width
- OT_DEPTH, 2, max outstanding requests; legal values 2 or 4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_req_addr / r1_req_addr  in  AW  request address
- r0_req_wen / r1_req_wen  in  1  1 = write, 0 = read
- r0_req_wdata / r1_req_wdata  in  DW  write data
- r0_req_valid / r1_req_valid  in  1  request offered
- r0_req_ready / r1_req_ready  out  1  request accepted this cycle
- r0_resp_rdata / r1_resp_rdata  out  DW  response data (pass-through of m_resp_rdata)
- r0_resp_valid / r1_resp_valid  out  1  response beat for this requester
- m_req_addr / m_req_wen / m_req_wdata  out  AW/1/DW  muxed request
- m_req_valid  out  1  request offered downstream
- m_req_ready  in  1  downstream accepts
- m_resp_rdata  in  DW  response data
- m_resp_valid  in  1  response beat; always accepted, no back-pressure
- ot_count  out  3  current outstanding requests
- err_orphan_resp  out  1  one-cycle pulse: response arrived with ot_count == 0

## Operation
- Every accepted request, read or write, yields exactly one m_resp_valid beat. Responses return in issue order.
- State machine:
  - ARB, the reset state:
    - Select the requester: the only valid one, or if both are valid, the one named by the priority pointer `prio` (reset 0 = r0).
    - m_req_valid = selected valid && ot_count < OT_DEPTH.
    - Handshake (valid && m_req_ready): stay in ARB and set prio to the other requester.
    - Offer without ready: go to HOLD with `lock` = the selected requester.
  - HOLD:
    - Mux follows `lock` only. The new request of the other requester is ignored.
    - The locked requester keeps valid and payload stable (requester obligation; a bench assertion checks it).
    - Handshake: return to ARB and set prio to !lock.
- rN_req_ready = m_req_ready && m_req_valid && (mux source == N). It is never asserted for the non-selected requester.
- Tracker: ordered queue of OT_DEPTH owner bits, with a head pointer, a tail pointer (wrap modulo OT_DEPTH) and ot_count.
  - Push the owner on request handshake.
  - Pop the head on m_resp_valid when ot_count > 0.
  - Push and pop in the same cycle leave ot_count unchanged and advance both pointers.
- Response steering: rN_resp_valid = m_resp_valid && ot_count > 0 && head owner == N. Both rN_resp_rdata equal m_resp_rdata at all times.
- Full:
  - ot_count == OT_DEPTH forces m_req_valid = 0, even if a response arrives the same cycle. No resp→req combinational path.
  - HOLD state is kept while full.
- Orphan response (ot_count == 0): no rN_resp_valid, pointers unchanged, err_orphan_resp = 1 that cycle.
- Asynchronous reset (rst_n low):
  - State ← ARB, prio ← 0, pointers and ot_count ← 0.
  - m_req_valid, rN_req_ready, rN_resp_valid and err_orphan_resp are forced 0 while rst_n is low.
  - Reset mid-operation abandons outstanding entries. Their later responses are reported as orphans.

## Timing
- Request path is combinational, 0 cycles: requester valid → m_req_valid in the same cycle when the tracker is not full.
- Response path is combinational, 0 cycles: m_resp_valid → rN_resp_valid in the same cycle.
- ot_count and the tracker update on the clock edge after the handshake or response.
- Peak throughput is 1 request/cycle when m_req_ready is held high, responses keep pace, and the requesters alternate under contention.
- Outputs after reset release: ot_count = 0, err_orphan_resp = 0. m_req_valid follows the inputs from the first edge.

## Test plan
- Contention, ready always high: r0 and r1 both valid for 4 cycles → grants r0, r1, r0, r1. Responses with data 0xA0..0xA3 → r0 receives 0xA0 and 0xA2, r1 receives 0xA1 and 0xA3.
- Stall lock: r1 offers addr 0x1000 while m_req_ready = 0 for 3 cycles, and r0 becomes valid in cycle 1 → m_req_addr stays 0x1000 and r0_req_ready stays 0. r1 is accepted when ready rises, then r0 is granted the next cycle.
- Full, OT_DEPTH = 2: issue 2 requests with no responses → ot_count = 2 and m_req_valid = 0. A response in the same cycle still blocks the issue. The next cycle ot_count = 1 and an issue is allowed.
- Simultaneous push and pop at ot_count = 1: a handshake plus m_resp_valid in the same cycle → ot_count stays 1 and the owner order is preserved across pointer wrap (8 sustained cycles).
- Orphan: m_resp_valid with ot_count = 0 → err_orphan_resp pulses 1 cycle and neither rN_resp_valid is asserted.
- Reset mid-flight: ot_count = 2, rst_n asserted asynchronously mid-cycle → outputs are 0 immediately. After release ot_count = 0, and the two late responses each give an orphan pulse.
